lsnn_spike_monitor: RTL

Downstream consumer of the adaptive-threshold LIF neuron's spike output. For every spike it measures the inter-spike interval (ISI) and queues it in a small FIFO, drained through a valid/ready handshake. In parallel it publishes a windowed spike-rate count once per fixed window. It sits between the neuron's spike bit and the readout/IO logic.

---
 rtl/lsnn_spike_monitor_if.sv | 29 ++
 rtl/lsnn_spike_monitor.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lsnn_spike_monitor_if.sv
// ---------------------------------------------------------------------------
// lsnn_spike_monitor_if
//   Valid/ready stream that carries inter-spike-interval values from the
//   spike monitor's ISI FIFO to the readout logic.
//
//   out_valid : producer -> consumer, FIFO head is valid
//   out_isi   : producer -> consumer, FIFO head value (0 when empty)
//   out_ready : consumer -> producer, head is accepted this cycle
//
//   master : the monitor (drives valid/data)
//   slave  : the readout consumer (drives ready)
// ---------------------------------------------------------------------------
interface lsnn_spike_monitor_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_isi;

  modport master (
    output out_valid,
    output out_isi,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_isi,
    output out_ready
  );
endinterface

// File: rtl/lsnn_spike_monitor.sv
// ---------------------------------------------------------------------------
// lsnn_spike_monitor
//   Watches the spike bit of an adaptive-threshold LIF neuron. For every
//   spike it measures the inter-spike interval (ISI, saturating at 255) and
//   queues it in a small FIFO drained over a valid/ready stream. In parallel
//   it counts spikes over a fixed window of 2^WIN_LOG2 enabled cycles and
//   publishes the count once per window.
//
// Parameters
//   WIN_LOG2   : log2 of the rate window length, 1..8
//   FIFO_DEPTH : ISI FIFO entries, power of two, 2..16
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset, clears all state
//   ena        : freezes ISI/window/rate state when low (pop side still runs)
//   spike_in   : neuron spike bit, one spike per high cycle
//   isi_bus    : ISI stream (out_valid/out_isi out, out_ready in)
//   fifo_level : FIFO occupancy
//   overflow   : sticky, an ISI was dropped because the FIFO was full
//   rate_out   : spike count of the last completed window, saturating
//   rate_stb   : one-cycle pulse when rate_out updates
// ---------------------------------------------------------------------------
module lsnn_spike_monitor #(
  parameter int WIN_LOG2   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          spike_in,
  lsnn_spike_monitor_if.master          isi_bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    rate_out,
  output logic                          rate_stb
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic spike;
  assign spike = ena & spike_in;

  // -------------------------------------------------------------------------
  // ISI measurement
  // -------------------------------------------------------------------------
  logic       seen;
  logic [7:0] isi_cnt;
  logic [7:0] push_val;

  // The very first spike has no predecessor, so it reports 0.
  assign push_val = seen ? isi_cnt : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen    <= 1'b0;
      isi_cnt <= 8'd0;
    end else if (spike) begin
      seen    <= 1'b1;
      isi_cnt <= 8'd1;
    end else if (ena && seen && (isi_cnt != 8'hFF)) begin
      isi_cnt <= isi_cnt + 8'd1;
    end
  end

  // -------------------------------------------------------------------------
  // ISI FIFO
  // -------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          do_pop;
  logic          do_push;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = !empty && isi_bus.out_ready;
  // When full, a simultaneous pop frees the head slot, which is the slot
  // wr_ptr points at, so the write lands behind the remaining entries.
  assign do_push = spike && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'd0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_val;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (spike && full && !do_pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Outputs come from registered state only; out_ready never reaches them.
  assign isi_bus.out_valid = !empty;
  assign isi_bus.out_isi   = empty ? 8'd0 : mem[rd_ptr];
  assign fifo_level        = level;

  // -------------------------------------------------------------------------
  // Windowed spike rate
  // -------------------------------------------------------------------------
  logic [WIN_LOG2-1:0] win_cnt;
  logic [7:0]          spike_cnt;
  logic [8:0]          win_sum;
  logic                win_last;

  assign win_last = (win_cnt == {WIN_LOG2{1'b1}});
  assign win_sum  = {1'b0, spike_cnt} + {8'd0, spike};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      spike_cnt <= 8'd0;
      rate_out  <= 8'd0;
      rate_stb  <= 1'b0;
    end else begin
      rate_stb <= 1'b0;
      if (ena) begin
        win_cnt <= win_cnt + WIN_LOG2'(1);
        if (win_last) begin
          // The closing cycle's own spike still belongs to this window.
          rate_out  <= win_sum[8] ? 8'hFF : win_sum[7:0];
          spike_cnt <= 8'd0;
          rate_stb  <= 1'b1;
        end else if (spike && (spike_cnt != 8'hFF)) begin
          spike_cnt <= spike_cnt + 8'd1;
        end
      end
    end
  end

endmodule
